// File: rtl/alu36_if.sv
// rtl/alu36_if.sv - operand/result bundle for alu36; carry member exists only with ALU36_CARRY_EN
interface alu36_if;
    logic [35:0] a;
    logic [35:0] b;
    logic        sub;
    logic [35:0] sum;
    logic        sign;
    logic        ovf;
    logic        zero;
`ifdef ALU36_CARRY_EN
    logic        carry;

    modport master (output a, b, sub, input sum, sign, ovf, zero, carry);
    modport slave  (input a, b, sub, output sum, sign, ovf, zero, carry);
`else
    modport master (output a, b, sub, input sum, sign, ovf, zero);
    modport slave  (input a, b, sub, output sum, sign, ovf, zero);
`endif
endinterface

// File: rtl/alu36.sv
// rtl/alu36.sv - registered 36-bit add/sub on nine chained 4-bit CLA groups; ALU36_CARRY_EN adds carry-out
module alu36 (
    input  logic    clk,
    input  logic    rst_n,
    alu36_if.slave  bus
);
    logic [35:0] b_x;
    logic [35:0] gen;
    logic [35:0] prop;
    logic [36:0] c;
    logic [3:0]  g;
    logic [3:0]  p;
    logic        ci;
    logic [35:0] r;

    logic [35:0] sum_d, sum_q;
    logic        sign_d, sign_q;
    logic        ovf_d, ovf_q;
    logic        zero_d, zero_q;

    // Each group resolves its internal carries from its own g/p plus the incoming group carry
    always_comb begin
        b_x  = bus.b ^ {36{bus.sub}};
        gen  = bus.a & b_x;
        prop = bus.a ^ b_x;
        c    = '0;
        g    = '0;
        p    = '0;
        ci   = 1'b0;
        c[0] = bus.sub;
        for (int gi = 0; gi < 9; gi++) begin
            g  = gen[gi*4 +: 4];
            p  = prop[gi*4 +: 4];
            ci = c[gi*4];
            c[gi*4+1] = g[0] | (p[0] & ci);
            c[gi*4+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
            c[gi*4+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                      | (p[2] & p[1] & p[0] & ci);
            c[gi*4+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0])
                      | (p[3] & p[2] & p[1] & p[0] & ci);
        end
        r = prop ^ c[35:0];
    end

    always_comb begin
        sum_d  = r;
        sign_d = r[35];
        ovf_d  = (bus.a[35] == b_x[35]) && (r[35] != bus.a[35]);
        zero_d = (r == 36'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            sum_q  <= sum_d;
            sign_q <= sign_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.sign = sign_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

`ifdef ALU36_CARRY_EN
    logic carry_d, carry_q;

    always_comb begin
        carry_d = c[36];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign bus.carry = carry_q;
`endif
endmodule

// File: tb/tb_alu36.sv
// tb/tb_alu36.sv - directed and randomized checks of alu36 against an arithmetic reference model
module tb_alu36;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu36_if bus ();

    alu36 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] sum;
        logic        sign;
        logic        ovf;
        logic        zero;
        logic        carry;
    } res_t;

    // Plain integer arithmetic: unsigned result for sum/carry, exact signed result for overflow
    function automatic res_t model(input logic [35:0] a, input logic [35:0] b,
                                   input logic sub, input logic in_reset);
        res_t   res;
        longint ua, ub, us, sa, sb, exact;
        longint two36 = 64'sd68719476736;
        longint smax  = 64'sd34359738367;
        longint smin  = -64'sd34359738368;
        if (in_reset) begin
            res.sum = '0; res.sign = 1'b0; res.ovf = 1'b0; res.zero = 1'b1; res.carry = 1'b0;
            return res;
        end
        ua = longint'({28'd0, a});
        ub = longint'({28'd0, b});
        us = sub ? ua - ub : ua + ub;
        if (us < 0) us = us + two36;
        res.sum   = us[35:0];
        res.carry = sub ? (ua >= ub) : (ua + ub >= two36);
        sa = a[35] ? ua - two36 : ua;
        sb = b[35] ? ub - two36 : ub;
        exact = sub ? sa - sb : sa + sb;
        res.ovf  = (exact > smax) || (exact < smin);
        res.sign = res.sum[35];
        res.zero = (res.sum == 36'd0);
        return res;
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input res_t e);
        check({tag, ".sum"},  bus.sum,         e.sum);
        check({tag, ".sign"}, {35'd0, bus.sign}, {35'd0, e.sign});
        check({tag, ".ovf"},  {35'd0, bus.ovf},  {35'd0, e.ovf});
        check({tag, ".zero"}, {35'd0, bus.zero}, {35'd0, e.zero});
`ifdef ALU36_CARRY_EN
        check({tag, ".carry"}, {35'd0, bus.carry}, {35'd0, e.carry});
`endif
    endtask

    task automatic step(input string tag, input logic [35:0] a, input logic [35:0] b,
                        input logic sub, input logic rst);
        res_t e;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = sub; rst_n = ~rst;
        e = model(a, b, sub, rst);
        @(posedge clk);
        #1;
        check_all(tag, e);
    endtask

    initial begin
        res_t        e;
        logic [35:0] ra, rb;
        logic        rs;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.a = 36'h1_2345_6789; bus.b = 36'hF_0000_0001; bus.sub = 1'b0;

        step("reset",     36'h5_5555_5555, 36'h3_3333_3333, 1'b0, 1'b1);
        step("eq_sub",    36'd49,          36'd49,          1'b1, 1'b0);
        step("pos_ovf",   36'h7_FFFF_FFFF, 36'd1,           1'b0, 1'b0);
        step("neg_ovf",   36'h8_0000_0000, 36'd1,           1'b1, 1'b0);
        step("borrow",    36'd0,           36'd1,           1'b1, 1'b0);
        step("wrap_zero", 36'hF_FFFF_FFFF, 36'd1,           1'b0, 1'b0);
        step("min_sub",   36'd0,           36'h8_0000_0000, 1'b1, 1'b0);

        // Outputs must hold when inputs move between edges
        e = model(36'h0_0000_0003, 36'h0_0000_0004, 1'b0, 1'b0);
        step("hold_pre",  36'h0_0000_0003, 36'h0_0000_0004, 1'b0, 1'b0);
        bus.a = 36'hA_BCDE_F012; bus.b = 36'h1_1111_1111; bus.sub = 1'b1;
        #2;
        check_all("hold", e);

        rs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom_range(15, 0), $urandom()};
            rb = {$urandom_range(15, 0), $urandom()};
            if (i % 7 == 3) rb = ra;
            step($sformatf("rand%0d", i), ra, rb, rs, (i == 20));
            rs = ~rs;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu36.md
ALU36 -- requirements
Module: alu36

Interface
- REQ-001: No parameters; operand width fixed at 36 bits.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, synchronous, active-low.
- REQ-004: a  input  36  operand A, two's complement.
- REQ-005: b  input  36  operand B, two's complement.
- REQ-006: sub  input  1  operation select: 0 = a+b, 1 = a-b.
- REQ-007: sum  output  36  registered result, low 36 bits of the operation.
- REQ-008: sign  output  1  registered result sign, equal to sum[35].
- REQ-009: ovf  output  1  registered signed-overflow flag.
- REQ-010: zero  output  1  registered flag, 1 when sum == 0.
- REQ-011: carry  output  1  registered carry-out; present only when ALU36_CARRY_EN is defined.

Function
- REQ-012: The block SHALL compute r = a + (b XOR {36{sub}}) + sub, which yields a+b when sub=0 and a-b when sub=1.
- REQ-013: The 36-bit adder SHALL be built from nine 4-bit carry-lookahead groups chained group-to-group, with the group carry-in of group 0 equal to sub.
- REQ-014: Results SHALL be truncated modulo 2^36 with no saturation.
- REQ-015: ovf SHALL be 1 iff both adder operands (a and b XOR {36{sub}}) share a sign bit that differs from r[35].
- REQ-016: zero SHALL be computed from r, not from a or b.
- REQ-017: a, b and sub SHALL be sampled on each rising clk edge with rst_n=1, and all outputs SHALL update on that same edge (1-cycle latency, fully pipelined, no handshake, new result every cycle).
- REQ-018: Outputs SHALL hold their values between edges regardless of input changes.
- REQ-019: X-free inputs SHALL always produce X-free outputs; there are no illegal input combinations.

Reset
- REQ-020: On a rising clk edge with rst_n=0, the block SHALL set sum=0, sign=0, ovf=0, zero=1 and carry=0 (when present), ignoring a, b and sub.
- REQ-021: If reset is asserted mid-stream, the result sampled on that edge SHALL be discarded; the first edge with rst_n=1 SHALL produce a normal result from the inputs present at that edge.
- REQ-022: rst_n SHALL have no asynchronous effect.

Configuration
- REQ-023: When macro ALU36_CARRY_EN is defined, the carry port SHALL exist and register the adder carry-out of bit 35 (for sub=1, carry=1 means no borrow, i.e. a >= b unsigned).
- REQ-024: When ALU36_CARRY_EN is undefined, the carry port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-025: rst_n=0 for 1 edge -> sum=0, sign=0, ovf=0, zero=1 (carry=0).
- REQ-026: a=49, b=49, sub=1 -> next edge: sum=0, zero=1, sign=0, ovf=0 (carry=1).
- REQ-027: a=0x7_FFFF_FFFF, b=1, sub=0 -> sum=0x8_0000_0000, sign=1, ovf=1, zero=0 (carry=0).
- REQ-028: a=0x8_0000_0000, b=1, sub=1 -> sum=0x7_FFFF_FFFF, sign=0, ovf=1; then a=0, b=1, sub=1 -> sum=0xF_FFFF_FFFF, sign=1, ovf=0 (carry=0).
- REQ-029: a=0xF_FFFF_FFFF, b=1, sub=0 -> sum=0, zero=1, ovf=0 (carry=1).
- REQ-030: Back-to-back random 36-bit a/b with sub toggling every cycle, with rst_n pulsed low once mid-stream -> each output equals the reference model of the prior edge's inputs; the reset edge yields reset values; the following edge resumes normal results.
